// File: rtl/sa_act_skewer.sv
// Activation skewer for the systolic array: delays lane i by i extra cycles to
// form the diagonal wavefront, and drains the wavefront after a segment-last beat.
//
// state  | meaning
// IDLE   | no segment open; accepts beats
// STREAM | segment open; accepts beats until the segment-last beat
// DRAIN  | input blocked for ROWS-1 advances while the wavefront empties
module sa_act_skewer #(
  parameter int ROWS = 8,
  parameter int DW   = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [ROWS*DW-1:0]   s_data,
  input  logic                 s_last,
  input  logic                 m_ready,
  output logic [ROWS*DW-1:0]   m_data,
  output logic [ROWS-1:0]      m_lane_valid,
  output logic                 m_valid,
  output logic                 m_last,
  output logic                 busy
);

  localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [ROWS-1:0] last_q;
  logic [ROWS-1:0] lane_busy;
  logic            advance;
  logic            accept;
  logic            acc_last;

  assign advance  = m_ready;
  assign s_ready  = m_ready && (state_q != DRAIN);
  assign accept   = s_valid && s_ready;
  assign acc_last = accept && s_last;

  for (genvar i = 0; i < ROWS; i++) begin : g_lane
    logic [DW-1:0] data_q [0:i];
    logic [i:0]    vld_q;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        for (int s = 0; s <= i; s++) data_q[s] <= '0;
        vld_q <= '0;
      end else if (advance) begin
        data_q[0] <= accept ? s_data[i*DW +: DW] : '0;
        vld_q[0]  <= accept;
        for (int s = 1; s <= i; s++) begin
          data_q[s] <= data_q[s-1];
          vld_q[s]  <= vld_q[s-1];
        end
      end
    end

    assign m_data[i*DW +: DW] = vld_q[i] ? data_q[i] : '0;
    assign m_lane_valid[i]    = vld_q[i];
    assign lane_busy[i]       = |vld_q;
  end

  // Segment-last tag rides alongside the deepest lane so it emerges with it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_q <= '0;
    end else if (advance) begin
      last_q[0] <= acc_last;
      for (int s = 1; s < ROWS; s++) last_q[s] <= last_q[s-1];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else if (advance) begin
      case (state_q)
        IDLE, STREAM: begin
          if (acc_last) begin
            if (ROWS == 1) begin
              state_q <= IDLE;
            end else begin
              state_q <= DRAIN;
              cnt_q   <= CW'(ROWS - 1);
            end
          end else if (accept) begin
            state_q <= STREAM;
          end
        end
        DRAIN: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_valid = |m_lane_valid;
  assign m_last  = last_q[ROWS-1];
  assign busy    = (state_q != IDLE) || (|lane_busy);

endmodule
